// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with sequential/jump/branch/trap selection, stall hold, pending redirect and misalign fault
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              STEP         = 4,
   parameter int              ALIGN_BITS   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] j_addr,
   input  logic [XLEN-1:0] b_addr,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_step,
   output logic            redirect_taken,
   output logic            misalign_fault,
   output logic [XLEN-1:0] fault_addr
);
   localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} >> (XLEN - ALIGN_BITS);
   localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);

   logic [XLEN-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d, fault_addr_q, fault_addr_d, target;
   logic            pend_valid_q, pend_valid_d, pend_trap_q, pend_trap_d;
   logic            redir_q, redir_d, fault_q, fault_d;
   logic            is_trap, is_jb, misaligned, valid_redir;

   assign pc_plus_step   = pc_q + STEP_V;
   assign pc             = pc_q;
   assign redirect_taken = redir_q;
   assign misalign_fault = fault_q;
   assign fault_addr     = fault_addr_q;

   // Target selection, redirect qualification and next-state for PC and pending latch
   always_comb begin
      is_trap      = pc_src == 2'b11;
      is_jb        = pc_src[1] ^ pc_src[0];
      target       = pc_src == 2'b01 ? j_addr :
                     pc_src == 2'b10 ? b_addr :
                     is_trap         ? (trap_addr & ~ALIGN_MASK) : pc_plus_step;
      misaligned   = is_jb && ((target & ALIGN_MASK) != '0);
      valid_redir  = is_trap || (is_jb && !misaligned);
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_trap_d  = pend_trap_q;
      redir_d      = 1'b0;
      fault_d      = misaligned;
      fault_addr_d = misaligned ? target : fault_addr_q;
      if (!stall) begin
         pc_d         = valid_redir ? target : pend_valid_q ? pend_addr_q : pc_plus_step;
         redir_d      = valid_redir || pend_valid_q;
         pend_valid_d = 1'b0;
         pend_trap_d  = 1'b0;
      end else if (valid_redir && (is_trap || !(pend_valid_q && pend_trap_q))) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = target;
         pend_trap_d  = is_trap;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_VECTOR;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_trap_q  <= 1'b0;
         redir_q      <= 1'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_trap_q  <= pend_trap_d;
         redir_q      <= redir_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  pc_src = 2'b00;
   logic [31:0] j_addr = '0, b_addr = '0, trap_addr = '0;
   logic        stall = 1'b0;
   logic [31:0] pc, pc_plus_step, fault_addr;
   logic        redirect_taken, misalign_fault;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .j_addr(j_addr), .b_addr(b_addr),
      .trap_addr(trap_addr), .stall(stall), .pc(pc), .pc_plus_step(pc_plus_step),
      .redirect_taken(redirect_taken), .misalign_fault(misalign_fault), .fault_addr(fault_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        rt;
      logic        mf;
      logic [31:0] fa;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_pa, m_fa;
   bit          m_pv, m_pt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pa = 32'h0; m_fa = 32'h0; m_pv = 0; m_pt = 0;
      exp_q.delete();
   endtask

   // Apply one cycle of stimulus and predict the state after the next rising edge
   task automatic drive(input logic [1:0] src, input logic [31:0] j, input logic [31:0] b,
                        input logic [31:0] t, input bit st);
      logic [31:0] tgt;
      bit jb, bad, redir;
      exp_t e;
      @(negedge clk);
      pc_src = src; j_addr = j; b_addr = b; trap_addr = t; stall = st;
      #1;
      chk("pc_plus_step", pc_plus_step, m_pc + 32'd4);
      jb    = (src == 2'd1) || (src == 2'd2);
      tgt   = (src == 2'd1) ? j : (src == 2'd2) ? b : (t / 4) * 4;
      bad   = jb && (tgt % 4 != 0);
      redir = (src == 2'd3) || (jb && !bad);
      if (bad) m_fa = tgt;
      e.rt = 0;
      if (!st) begin
         if (redir) begin m_pc = tgt; e.rt = 1; end
         else if (m_pv) begin m_pc = m_pa; e.rt = 1; end
         else m_pc = m_pc + 32'd4;
         m_pv = 0; m_pt = 0;
      end else if (redir && (src == 2'd3 || !(m_pv && m_pt))) begin
         m_pv = 1; m_pa = tgt; m_pt = (src == 2'd3);
      end
      e.pc = m_pc; e.mf = bad; e.fa = m_fa;
      exp_q.push_back(e);
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++) drive(2'd0, 32'h0, 32'h0, 32'h0, 0);
   endtask

   // Monitor: compare the DUT against the oldest prediction after each edge
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc", pc, e.pc);
         chk("redirect_taken", {31'd0, redirect_taken}, {31'd0, e.rt});
         chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, e.mf});
         chk("fault_addr", fault_addr, e.fa);
      end
   end

   initial begin
      logic [31:0] r, a;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset_pc", pc, 32'h0);
      chk("reset_rt", {31'd0, redirect_taken}, 32'd0);
      chk("reset_mf", {31'd0, misalign_fault}, 32'd0);
      chk("reset_fa", fault_addr, 32'h0);
      #1 rst_n = 1'b1;
      seq(4);
      drive(2'd1, 32'h200, 32'h0, 32'h0, 0);
      seq(1);
      drive(2'd2, 32'h0, 32'h80, 32'h0, 1);
      drive(2'd0, 32'h0, 32'h0, 32'h0, 1);
      drive(2'd0, 32'h0, 32'h0, 32'h0, 1);
      drive(2'd0, 32'h0, 32'h0, 32'h0, 0);
      @(posedge clk); #2 chk("branch_after_stall", pc, 32'h80);
      drive(2'd3, 32'h0, 32'h0, 32'h103, 1);
      drive(2'd1, 32'h400, 32'h0, 32'h0, 1);
      drive(2'd0, 32'h0, 32'h0, 32'h0, 0);
      @(posedge clk); #2 chk("trap_kept", pc, 32'h100);
      drive(2'd1, 32'h20, 32'h0, 32'h0, 0);
      drive(2'd1, 32'h202, 32'h0, 32'h0, 0);
      @(posedge clk); #2 chk("misalign_pc", pc, 32'h24);
      chk("misalign_fa", fault_addr, 32'h202);
      drive(2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
      seq(1);
      @(posedge clk); #2 chk("wrap_pc", pc, 32'h0);
      drive(2'd1, 32'h300, 32'h0, 32'h0, 1);
      @(negedge clk); #2 rst_n = 1'b0;
      #1 chk("async_reset_pc", pc, 32'h0);
      model_reset();
      @(posedge clk); #3 rst_n = 1'b1;
      seq(2);
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         a = $urandom_range(0, 7) == 0 ? r : r & 32'hFFFF_FFFC;
         drive(2'($urandom_range(0, 3)), a, a ^ 32'h1000, $urandom, $urandom_range(0, 9) < 3);
      end
      seq(3);
      @(posedge clk); #2;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit; successor to the fixed 3-way next-PC mux. Owns the PC register and selects the next PC from four sources: sequential, jump, branch or trap. Adds stall hold, a pending-redirect latch so no redirect is lost while stalled, trap-vector alignment and misaligned-target fault detection. Sits between the control unit/ALU branch resolution and the instruction fetch unit.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low target bits that must be zero; 0 disables the alignment check

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
pc_src  input  2  00 sequential, 01 jump, 10 branch, 11 trap
j_addr  input  XLEN  jump target
b_addr  input  XLEN  branch target
trap_addr  input  XLEN  trap/exception vector
stall  input  1  1 = hold PC this cycle
pc  output  XLEN  current PC (registered)
pc_plus_step  output  XLEN  pc + STEP (combinational, mod 2^XLEN)
redirect_taken  output  1  registered pulse: PC was loaded from a redirect in the previous edge
misalign_fault  output  1  registered pulse: misaligned jump/branch target rejected
fault_addr  output  XLEN  offending target; updated only when misalign_fault is set

Behaviour:
- Reset (rst_n=0, async): pc=RESET_VECTOR, pending_valid=0, pending_addr=0, pending_is_trap=0, redirect_taken=0, misalign_fault=0, fault_addr=0.
- Target selection (combinational): jump -> j_addr; branch -> b_addr; trap -> trap_addr with bits [ALIGN_BITS-1:0] forced to 0. All 4 codes defined; no latch inferred.
- Valid redirect: pc_src=11, or pc_src in {01,10} with target[ALIGN_BITS-1:0]==0.
- Misaligned jump/branch: no redirect and nothing latched. Next edge: misalign_fault=1, fault_addr=target. PC follows the stall/sequential rule as if pc_src=00. Traps are never faulted.
- stall=0 at edge, in priority order:
  - valid redirect this cycle -> pc=target; pending cleared; redirect_taken=1.
  - else pending_valid -> pc=pending_addr; pending cleared; redirect_taken=1.
  - else pc=pc+STEP (wraps modulo 2^XLEN); redirect_taken=0.
- stall=1 at edge: pc holds; redirect_taken=0.
  - Valid redirect is latched into pending.
  - A newer redirect overwrites pending, except that a non-trap never overwrites a pending trap.
  - A trap always overwrites pending.
- redirect_taken and misalign_fault are single-cycle pulses; both clear on the next edge unless re-triggered.
- Reset asserted mid-stall discards pending; the first edge after release starts from RESET_VECTOR.
- Latency: target presented in cycle N appears on pc after the edge ending cycle N (1 cycle) when not stalled.

Test Plan:
- Reset then 3 edges with pc_src=00, stall=0 -> pc: 0x0, 0x4, 0x8, 0xC; redirect_taken=0 throughout.
- pc=0x10, pc_src=01, j_addr=0x200 -> pc=0x200, redirect_taken=1 for one cycle, then pc=0x204.
- stall=1, pc_src=10 with b_addr=0x80, then 2 stalled cycles with pc_src=00, then stall=0 -> pc holds, then pc=0x80 with redirect_taken=1.
- stall=1: trap_addr=0x103, then jump 0x400 while still stalled; release stall -> pc=0x100 (trap kept, low bits cleared).
- pc_src=01, j_addr=0x202, pc=0x20 -> misalign_fault=1, fault_addr=0x202, pc=0x24.
- XLEN=32, pc=0xFFFF_FFFC, pc_src=00 -> pc=0x0000_0000; pc_plus_step=0x0 in the preceding cycle.
